// File: rtl/cam_read_pkg.sv
// Shared definitions for the OV7670 capture path and the VGA-side address logic.
package cam_read_pkg;

  // Default frame geometry, also used by the VGA-side frame-buffer addressing.
  localparam int CAM_SCREEN_X_DEF = 160;
  localparam int CAM_SCREEN_Y_DEF = 120;

  // Capture FSM states.
  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    BYTE1,
    BYTE2
  } cam_state_e;

  // RGB565 bit fields kept in the RGB332 pixel (top bits of each channel).
  localparam int R_MSB = 15;
  localparam int R_LSB = 13;
  localparam int G_MSB = 10;
  localparam int G_LSB = 8;
  localparam int B_MSB = 4;
  localparam int B_LSB = 3;

  function automatic logic [7:0] rgb565_to_rgb332(input logic [15:0] p565);
    return {p565[R_MSB:R_LSB], p565[G_MSB:G_LSB], p565[B_MSB:B_LSB]};
  endfunction

endpackage

// File: rtl/cam_read_sync_edge.sv
// Two-flop synchroniser for an asynchronous camera control line, with
// rise/fall pulses derived from the synchronised level.
module cam_read_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic prev;

  // Synchronise the input and keep last cycle's synchronised value for edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= d;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~prev;
  assign fall  = ~s2 & prev;

endmodule

// File: rtl/cam_read.sv
// OV7670 pixel capture: oversamples the camera bus on clk, pairs RGB565 bytes,
// converts to RGB332 and writes one pixel per cycle-wide strobe into the frame buffer.
module cam_read
  import cam_read_pkg::*;
#(
  parameter int AW           = 15,
  parameter int DW           = 8,
  parameter int CAM_SCREEN_X = CAM_SCREEN_X_DEF,
  parameter int CAM_SCREEN_Y = CAM_SCREEN_Y_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          pclk,
  input  logic          href,
  input  logic          vsync,
  input  logic [DW-1:0] px_data,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr,
  output logic          frame_done,
  output logic          overflow
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(CAM_SCREEN_X * CAM_SCREEN_Y - 1);

  logic          pclk_s, pclk_rise, pclk_fall;
  logic          href_s, href_rise, href_fall;
  logic          vsync_s, vsync_rise, vsync_fall;
  logic [DW-1:0] px_d1;
  logic [DW-1:0] px_d;
  logic [DW-1:0] byte1;
  logic          full;
  cam_state_e    state;

  cam_read_sync_edge u_sync_pclk (
    .clk(clk), .rst(rst), .d(pclk), .level(pclk_s), .rise(pclk_rise), .fall(pclk_fall)
  );

  cam_read_sync_edge u_sync_href (
    .clk(clk), .rst(rst), .d(href), .level(href_s), .rise(href_rise), .fall(href_fall)
  );

  cam_read_sync_edge u_sync_vsync (
    .clk(clk), .rst(rst), .d(vsync), .level(vsync_s), .rise(vsync_rise), .fall(vsync_fall)
  );

  // Edge outputs that the capture logic has no use for.
  logic unused_edges;
  assign unused_edges = pclk_s | pclk_fall | href_rise;

  // Delay the data byte by the same two flops so it lines up with pclk_rise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      px_d1 <= '0;
      px_d  <= '0;
    end else begin
      px_d1 <= px_data;
      px_d  <= px_d1;
    end
  end

  // Capture FSM with registered write strobe, address, pixel and status flags.
  // The address advances the cycle after each write and saturates at the last
  // pixel; 'full' remembers that the last pixel has been written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      mem_px_addr <= '0;
      mem_px_data <= '0;
      px_wr       <= 1'b0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      byte1       <= '0;
      full        <= 1'b0;
    end else begin
      px_wr      <= 1'b0;
      frame_done <= 1'b0;
      if (px_wr) begin
        if (mem_px_addr == LAST_ADDR) full <= 1'b1;
        else                          mem_px_addr <= mem_px_addr + AW'(1);
      end
      case (state)
        IDLE: begin
          if (vsync_s) state <= WAIT_START;
        end
        WAIT_START: begin
          if (vsync_fall) begin
            if (en) begin
              state       <= BYTE1;
              mem_px_addr <= '0;
              overflow    <= 1'b0;
              full        <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        BYTE1: begin
          if (vsync_rise) begin
            frame_done <= 1'b1;
            state      <= WAIT_START;
          end else if (pclk_rise && href_s) begin
            byte1 <= px_d;
            state <= BYTE2;
          end
        end
        BYTE2: begin
          if (vsync_rise) begin
            frame_done <= 1'b1;
            state      <= WAIT_START;
          end else if (href_fall) begin
            state <= BYTE1;
          end else if (pclk_rise && href_s) begin
            state <= BYTE1;
            if (full) begin
              overflow <= 1'b1;
            end else begin
              px_wr       <= 1'b1;
              mem_px_data <= DW'(rgb565_to_rgb332({byte1, px_d}));
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_read.sv
// Self-checking bench for cam_read with a reduced frame geometry.
module tb_cam_read;

  localparam int SX = 16;
  localparam int SY = 6;
  localparam int N  = SX * SY;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic       pclk = 1'b0;
  logic       href = 1'b0;
  logic       vsync = 1'b0;
  logic [7:0] px_data = 8'h00;
  logic [6:0] mem_px_addr;
  logic [7:0] mem_px_data;
  logic       px_wr;
  logic       frame_done;
  logic       overflow;

  cam_read #(.AW(7), .DW(8), .CAM_SCREEN_X(SX), .CAM_SCREEN_Y(SY)) dut (
    .clk(clk), .rst(rst), .en(en), .pclk(pclk), .href(href), .vsync(vsync),
    .px_data(px_data), .mem_px_addr(mem_px_addr), .mem_px_data(mem_px_data),
    .px_wr(px_wr), .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct { int addr; int data; } wr_t;
  wr_t exp_q[$];
  int  m_cnt = 0;
  bit  m_cap = 1'b0;
  bit  m_ovf = 1'b0;
  int  m_done = 0;

  int  wr_seen = 0;
  int  done_seen = 0;
  int  last_addr = -1;
  int  last_data = -1;
  bit  prev_wr = 1'b0;
  bit  prev_done = 1'b0;
  int  prev_addr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Compare process: every write against the expected-write queue.
  always @(negedge clk) begin
    wr_t e;
    if (prev_wr && rst)
      check("addr_step", 32'(mem_px_addr), 32'((prev_addr == N - 1) ? prev_addr : prev_addr + 1));
    if (px_wr) begin
      wr_seen++;
      check("wr_one_cycle", 32'(prev_wr), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_px_addr), 32'(e.addr));
        check("wr_data", 32'(mem_px_data), 32'(e.data));
      end
      last_addr = int'(mem_px_addr);
      last_data = int'(mem_px_data);
    end
    if (frame_done) begin
      done_seen++;
      check("done_one_cycle", 32'(prev_done), 32'd0);
    end
    prev_wr   = px_wr;
    prev_done = frame_done;
    prev_addr = int'(mem_px_addr);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: a complete pixel in a captured frame lands at the next free
  // address until the frame is full; beyond that it only raises overflow.
  task automatic model_pixel(input logic [7:0] b1, input logic [7:0] b2);
    int p;
    int v;
    p = int'({b1, b2});
    v = (p / 8192) * 32 + ((p / 256) % 8) * 4 + (p / 8) % 4;
    if (!m_cap) return;
    if (m_cnt < N) begin
      exp_q.push_back('{addr: m_cnt, data: v});
      m_cnt++;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    px_data = b;
    tick(int'($urandom_range(2, 3)));
    pclk = 1'b1;
    tick(int'($urandom_range(2, 3)));
    pclk = 1'b0;
  endtask

  task automatic send_line(input logic [7:0] bytes[$]);
    href = 1'b1;
    tick(2);
    for (int i = 0; i < bytes.size(); i++) begin
      send_byte(bytes[i]);
      if (i % 2 == 1) model_pixel(bytes[i-1], bytes[i]);
    end
    tick(2);
    href = 1'b0;
    tick(4);
  endtask

  task automatic rand_line(input int n);
    logic [7:0] q[$];
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    send_line(q);
  endtask

  task automatic line_check();
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("frame_done_count", 32'(done_seen), 32'(m_done));
  endtask

  task automatic vsync_pulse(input bit e);
    en = e;
    vsync = 1'b1;
    if (m_cap) m_done++;
    tick(6);
    vsync = 1'b0;
    m_cap = e;
    if (e) begin
      m_cnt = 0;
      m_ovf = 1'b0;
    end
    tick(6);
    line_check();
  endtask

  task automatic check_reset_outputs();
    check("rst_addr", 32'(mem_px_addr), 32'd0);
    check("rst_data", 32'(mem_px_data), 32'd0);
    check("rst_wr", 32'(px_wr), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
  endtask

  initial begin
    int w0;
    int nl;
    // Reset held while the camera lines toggle.
    for (int i = 0; i < 4; i++) begin
      pclk  = ~pclk;
      href  = 1'($urandom);
      vsync = 1'($urandom);
      px_data = 8'($urandom);
      tick(3);
      check_reset_outputs();
    end
    pclk = 1'b0; href = 1'b0; vsync = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(4);

    // No vsync yet: nothing may be written.
    rand_line(8);
    line_check();

    // Single pixel, then the next pixel at address 1.
    vsync_pulse(1'b1);
    send_line('{8'hF8, 8'h1F});
    line_check();
    check("single_addr", 32'(last_addr), 32'd0);
    check("single_data", 32'(last_data), 32'hE3);
    rand_line(2);
    check("second_addr", 32'(last_addr), 32'd1);

    // Odd-byte line: trailing byte dropped, next line continues at 2.
    vsync_pulse(1'b1);
    w0 = wr_seen;
    send_line('{8'hFF, 8'hFF, 8'h07, 8'hE0, 8'hAA});
    line_check();
    check("odd_writes", 32'(wr_seen - w0), 32'd2);
    check("odd_addr", 32'(last_addr), 32'd1);
    check("odd_data", 32'(last_data), 32'h1C);
    send_line('{8'h12, 8'h34});
    check("odd_next_addr", 32'(last_addr), 32'd2);

    // Full frame.
    vsync_pulse(1'b1);
    w0 = wr_seen;
    for (int l = 0; l < SY; l++) begin
      rand_line(2 * SX);
      line_check();
    end
    check("full_writes", 32'(wr_seen - w0), 32'(N));
    check("full_last_addr", 32'(last_addr), 32'(N - 1));
    check("full_ovf", 32'(overflow), 32'd0);
    vsync_pulse(1'b1);
    rand_line(2);
    check("next_frame_addr", 32'(last_addr), 32'd0);

    // Overflow frame: one extra line.
    vsync_pulse(1'b1);
    w0 = wr_seen;
    for (int l = 0; l < SY + 1; l++) begin
      rand_line(2 * SX);
      line_check();
    end
    check("ovf_writes", 32'(wr_seen - w0), 32'(N));
    check("ovf_set", 32'(overflow), 32'd1);
    vsync_pulse(1'b1);
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Randomised frames with random enable and line lengths.
    for (int f = 0; f < 6; f++) begin
      vsync_pulse($urandom_range(0, 3) != 0);
      nl = int'($urandom_range(1, SY + 1));
      for (int l = 0; l < nl; l++) begin
        rand_line(int'($urandom_range(1, 2 * SX + 3)));
        line_check();
      end
    end

    // Reset in the middle of a line.
    vsync_pulse(1'b1);
    href = 1'b1;
    tick(2);
    for (int i = 0; i < 10; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      a = 8'($urandom);
      b = 8'($urandom);
      send_byte(a);
      send_byte(b);
      model_pixel(a, b);
    end
    tick(8);
    check("pre_reset_addr", 32'(mem_px_addr), 32'd10);
    rst = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    m_cap = 1'b0; m_cnt = 0; m_ovf = 1'b0;
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    check_reset_outputs();
    href = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(4);
    rand_line(6);
    line_check();
    vsync_pulse(1'b1);
    rand_line(4);
    check("post_reset_addr", 32'(last_addr), 32'd1);

    // Capture disabled at frame start.
    vsync_pulse(1'b0);
    w0 = wr_seen;
    rand_line(2 * SX);
    rand_line(7);
    line_check();
    check("en0_writes", 32'(wr_seen - w0), 32'd0);
    vsync_pulse(1'b1);
    rand_line(2);
    line_check();
    check("en1_addr", 32'(last_addr), 32'd0);

    tick(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cam_read.md
Name: cam_read

Overview:
- OV7670 pixel-capture stage; sits directly upstream of the dual-port frame buffer (buffer_ram_dp write port).
- Oversamples camera pclk/href/vsync/data on the system clock.
- Assembles two RGB565 bytes per pixel, converts each pixel to RGB332, and issues one write per pixel with a linear frame-buffer address.
- Raw-pixel overflow and frame-done status feed the top level.

Parameters:
- AW, 15, frame-buffer address width (ceil(log2(CAM_SCREEN_X*CAM_SCREEN_Y))).
- DW, 8, camera byte width and RGB332 pixel width.
- CAM_SCREEN_X, 160, pixels per line.
- CAM_SCREEN_Y, 120, lines per frame.

Ports:
- clk  in  1  system clock (100 MHz); same clock as the frame-buffer write port.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  capture enable; sampled only at frame start.
- pclk  in  1  camera pixel clock (asynchronous, ≤25 MHz).
- href  in  1  camera line-valid (asynchronous).
- vsync  in  1  camera frame sync, active-high (asynchronous).
- px_data  in  DW  camera data byte (asynchronous).
- mem_px_addr  out  AW  frame-buffer write address.
- mem_px_data  out  DW  RGB332 pixel to write.
- px_wr  out  1  write strobe, one clk cycle per pixel.
- frame_done  out  1  one-cycle pulse when a frame completes.
- overflow  out  1  sticky flag: more than X*Y pixels arrived in a frame.

Behaviour:
- Synchronisers:
  - pclk, href, vsync and px_data each pass through 2-FF synchronisers; px_data is delayed so it stays aligned with pclk.
  - pclk rise = sync pclk 1 this cycle and 0 the previous cycle.
  - vsync fall is detected the same way.
  - All decisions use synchronised values only.
- Reset (rst=0, asynchronous): state=IDLE; mem_px_addr=0, mem_px_data=0, px_wr=0, frame_done=0, overflow=0; byte register cleared.
- FSM states:
  - IDLE: wait for vsync=1.
  - WAIT_START: wait for vsync fall. Then go to BYTE1 if en=1, else stay in IDLE. Entering BYTE1 clears the address to 0 and clears overflow.
  - BYTE1: on pclk rise with href=1, latch byte → BYTE2.
  - BYTE2: on pclk rise with href=1, form pixel → BYTE1 and issue a write.
  - In BYTE1/BYTE2, vsync rise → frame_done pulse → WAIT_START.
- Pixel format:
  - The first byte is the high byte: p565 = {byte1, byte2}.
  - RGB332 = {p565[15:13], p565[10:8], p565[4:3]}.
- Write timing:
  - px_wr rises the cycle after the pclk rise that captured byte2. It is high exactly 1 clk.
  - mem_px_addr and mem_px_data are stable during px_wr.
  - mem_px_addr increments the cycle after px_wr.
- Line end: if href falls while in BYTE2, the half pixel is discarded and the FSM returns to BYTE1. No write is issued.
- Address bound:
  - Writes occur only while addr ≤ X*Y−1.
  - After the write at X*Y−1, the address stays at X*Y−1.
  - Any further complete pixel suppresses px_wr and sets overflow. overflow stays set until the next frame start or reset.
  - The address never wraps.
- frame_done:
  - Fires on vsync rise while in BYTE1/BYTE2, 1 clk wide.
  - It fires even if fewer than X*Y pixels were written.
- Simultaneous events: vsync rise in the same cycle as a pclk rise → vsync wins. The byte is dropped and no write is issued.
- Reset mid-frame: all outputs return immediately to their reset values, and capture resumes only after a full vsync pulse.
- Timing requirement: clk ≥ 4× pclk. The pclk high and low phases must each be ≥ 2 clk periods.

Decomposition:
- Shared package: the FSM state encoding (IDLE, WAIT_START, BYTE1, BYTE2), the RGB565→RGB332 bit-slice constants, and the CAM_SCREEN_X/Y defaults, which the VGA-side address logic also uses.
- Sub-module sync_edge: 2-FF synchroniser plus rise/fall detector. Instantiate it for pclk, href and vsync; px_data uses a plain 2-FF delay.

Test Plan:
- Reset/idle: hold rst=0 while toggling pclk → all outputs 0. Release rst with no vsync → px_wr never asserts.
- Single pixel: vsync pulse, then href=1 with bytes 0xF8,0x1F (565 = 0xF81F) → exactly one px_wr with mem_px_addr=0 and mem_px_data=0xE3. The next pixel is written at addr 1.
- Odd-byte line: href line carrying 5 bytes (0xFF,0xFF,0x07,0xE0,0xAA) → two writes (0xFF at addr 0, 0x1C at addr 1). The trailing 0xAA is discarded, and the next line starts at addr 2.
- Full frame: 120 lines × 160 pixels at pclk = clk/4, then vsync rise → 19200 writes, final addr 19199, overflow=0, one frame_done pulse. The next frame starts at addr 0.
- Overflow: 121 lines × 160 pixels → 19200 writes, no px_wr for the extra 160 pixels, overflow=1. overflow clears at the next vsync fall.
- Reset mid-line and en=0: assert rst during pixel 50 → outputs reset, and the next frame starts at addr 0. With en=0 at vsync fall → zero writes for that frame.
